// File: rtl/multiply_divide_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package multiply_divide_unit_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } MdOp;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } MdState;

    function automatic logic op_is_signed(input MdOp op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_mul(input MdOp op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic op_is_div(input MdOp op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/multiply_divide_unit_md_iter_step.sv
// One combinational iteration of the HI/LO datapath: radix-2 shift-add
// multiply step or one restoring-division step on magnitudes.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        add_sum  = {1'b0, acc} + (q[0] ? {1'b0, operand} : '0);
        shifted  = {acc, q[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = '0;
        q_next   = '0;
        if (mode_div) begin
            // Partial remainder stays below the divisor, so diff's MSB is the borrow.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = add_sum[WIDTH:1];
            q_next   = {add_sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multiply_divide_unit.sv
// Iterative HI/LO unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO; holds the
// architectural HI/LO registers and stalls the pipeline through busy.
module multiply_divide_unit
    import multiply_divide_unit_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter bit DIV0_KEEP_HILO = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    MdState           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] opnd;
    logic             mode_div;
    logic             neg_res;
    logic             neg_rem;

    MdOp              op;
    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] q_next;

    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy   = (state != MD_IDLE);
    assign op     = MdOp'(md_op);
    assign accept = start && !busy && !flush;

    always_comb begin
        signed_op = op_is_signed(op);
        a_abs     = (signed_op && operand1[WIDTH-1]) ? -operand1 : operand1;
        b_abs     = (signed_op && operand2[WIDTH-1]) ? -operand2 : operand2;
    end

    md_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode_div(mode_div),
        .acc     (acc),
        .q       (q_reg),
        .operand (opnd),
        .acc_next(acc_next),
        .q_next  (q_next)
    );

    // Divide-by-zero needs no special remainder path: the restoring loop
    // leaves |dividend| in acc, and the sign fix-up restores the dividend.
    always_comb begin
        prod_raw = {acc, q_reg};
        prod_fix = neg_res ? -prod_raw : prod_raw;
        quo_fix  = neg_res ? -q_reg : q_reg;
        rem_fix  = neg_rem ? -acc : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            cnt         <= '0;
            acc         <= '0;
            q_reg       <= '0;
            opnd        <= '0;
            mode_div    <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        div_by_zero <= op_is_div(op) && (operand2 == '0);
                        if (op == MD_MTHI) begin
                            hi <= operand1;
                        end else if (op == MD_MTLO) begin
                            lo <= operand1;
                        end else if (op_is_mul(op) || op_is_div(op)) begin
                            state    <= MD_RUN;
                            cnt      <= '0;
                            acc      <= '0;
                            q_reg    <= a_abs;
                            opnd     <= b_abs;
                            mode_div <= op_is_div(op);
                            neg_res  <= signed_op && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                            neg_rem  <= signed_op && operand1[WIDTH-1];
                        end
                    end
                end
                MD_RUN: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        cnt   <= '0;
                    end else begin
                        acc   <= acc_next;
                        q_reg <= q_next;
                        if (cnt == CNT_LAST) begin
                            state <= MD_FIX;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!mode_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (div_by_zero) begin
                            if (!DIV0_KEEP_HILO) begin
                                hi <= rem_fix;
                                lo <= '1;
                            end
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
